// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_rr_arbiter
// Description : Round-robin arbiter sharing one resource between N requesters.
//               A one-hot priority token (o_ptr) marks the highest-priority
//               position; the search starts there and wraps N-1 -> 0. After a
//               grant is released the token moves one position past the owner.
//               A grant is held until i_done, owner request drop, or hold
//               timeout (MAX_HOLD cycles; 0 disables the timeout).
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               i_req      [N]  level requests, held while wanting access
//               i_done     owner pulse: transfer finished
//               o_gnt      [N]  one-hot grant, zero while idle
//               o_gnt_id   binary owner index, valid while o_busy=1
//               o_busy     1 while a grant is active
//               o_ptr      [N]  one-hot priority token
//               o_timeout  one-cycle pulse when a grant is revoked by timeout
// Revision    : 1.0  initial release
// ============================================================================
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         i_req,
  input  logic                                 i_done,
  output logic [N-1:0]                         o_gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_gnt_id,
  output logic                                 o_busy,
  output logic [N-1:0]                         o_ptr,
  output logic                                 o_timeout
);

  localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_idx_w:0]  c_n_ext     = (c_idx_w + 1)'(N);
  localparam bit                c_to_en     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]  c_hold_last = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [N-1:0]         r_gnt;
  logic [c_idx_w-1:0]   r_gnt_id;
  logic                 r_busy;
  logic [N-1:0]         r_ptr;
  logic [CNT_W-1:0]     r_hold_cnt;
  logic                 r_timeout;

  state_t               w_nxt_state;
  logic [N-1:0]         w_nxt_gnt;
  logic [c_idx_w-1:0]   w_nxt_gnt_id;
  logic                 w_nxt_busy;
  logic [N-1:0]         w_nxt_ptr;
  logic [CNT_W-1:0]     w_nxt_hold_cnt;
  logic                 w_nxt_timeout;

  logic [c_idx_w-1:0]   w_ptr_idx;
  logic [2*N-1:0]       w_req_rot;
  logic                 w_found;
  logic [c_idx_w:0]     w_win_sum;
  logic [c_idx_w-1:0]   w_win_idx;
  logic                 w_owner_req;
  logic                 w_hold_expired;
  logic                 w_release;

  // Binary position of the one-hot token.
  always_comb begin
    w_ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) w_ptr_idx = c_idx_w'(i);
    end
  end

  // Rotate the doubled request vector so that bit 0 lines up with the token;
  // the first set bit at offset j is requester (ptr + j) mod N.
  assign w_req_rot = {i_req, i_req} >> w_ptr_idx;

  always_comb begin
    w_found   = 1'b0;
    w_win_sum = '0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_req_rot[j]) begin
        w_found   = 1'b1;
        w_win_sum = {1'b0, w_ptr_idx} + (c_idx_w + 1)'(j);
      end
    end
    w_win_idx = (w_win_sum >= c_n_ext) ? c_idx_w'(w_win_sum - c_n_ext)
                                       : c_idx_w'(w_win_sum);
  end

  assign w_owner_req    = i_req[r_gnt_id];
  assign w_hold_expired = c_to_en && (r_hold_cnt == c_hold_last);
  assign w_release      = i_done || !w_owner_req || w_hold_expired;

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_gnt      = r_gnt;
    w_nxt_gnt_id   = r_gnt_id;
    w_nxt_busy     = r_busy;
    w_nxt_ptr      = r_ptr;
    w_nxt_hold_cnt = r_hold_cnt;
    w_nxt_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state    = BUSY;
          w_nxt_gnt      = N'(1) << w_win_idx;
          w_nxt_gnt_id   = w_win_idx;
          w_nxt_busy     = 1'b1;
          w_nxt_hold_cnt = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_nxt_state   = IDLE;
          w_nxt_gnt     = '0;
          w_nxt_busy    = 1'b0;
          // Token moves one past the owner; top bit wraps to bit 0.
          w_nxt_ptr     = {r_gnt[N-2:0], r_gnt[N-1]};
          // Timeout flagged only when neither done nor request drop caused it.
          w_nxt_timeout = w_hold_expired && !i_done && w_owner_req;
        end else if (r_hold_cnt != '1) begin
          w_nxt_hold_cnt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = '0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= N'(1);
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_gnt      <= w_nxt_gnt;
      r_gnt_id   <= w_nxt_gnt_id;
      r_busy     <= w_nxt_busy;
      r_ptr      <= w_nxt_ptr;
      r_hold_cnt <= w_nxt_hold_cnt;
      r_timeout  <= w_nxt_timeout;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_busy    = r_busy;
  assign o_ptr     = r_ptr;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire
